map_checkpoint_ctrl: RTL and testbench
======================================

MAP_CHECKPOINT_CTRL -- requirements
Module: map_checkpoint_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CKPT, default 4, meaning the number of branch checkpoint slots (power of two, at least 2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clock and reset_n.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 alloc_req  in  1  dispatch requests a checkpoint for one branch.
REQ-006 alloc_snapshot  in  MAP_ENTRY[`ARCH_REG_SZ]  speculative map table image to save.
REQ-007 alloc_gnt  out  1  checkpoint accepted this cycle (combinational).
REQ-008 alloc_id  out  CKPT_IDX  slot assigned; valid when alloc_gnt is 1.
REQ-009 resolve_valid  in  1  branch resolved this cycle.
REQ-010 resolve_id  in  CKPT_IDX  slot of the resolving branch.
REQ-011 resolve_mispredict  in  1  resolved branch mispredicted.
REQ-012 cdb_broadcasts  in  CDB_ENTRY[`N]  completing tags.
REQ-013 restore_table  out  MAP_ENTRY[`ARCH_REG_SZ]  table to load into the speculative map table.
REQ-014 restore_en  out  1  load strobe for the map table, one cycle wide.
REQ-015 busy  out  1  recovery in progress; dispatch must stall.
REQ-016 full  out  1  all slots in use.
REQ-017 count  out  $clog2(NUM_CKPT+1)  number of live checkpoints.

Function
REQ-018 Slots SHALL form a circular buffer with pointers head (oldest) and tail (next free); pointers wrap modulo NUM_CKPT.
REQ-019 alloc_gnt SHALL equal alloc_req AND NOT full AND state==IDLE AND NOT (resolve_valid AND resolve_mispredict AND the resolve is accepted).
REQ-020 On grant, the block SHALL copy alloc_snapshot into slot tail, mark it valid and unresolved, set alloc_id=tail, and increment tail.
REQ-021 A correct resolve (mispredict=0) of a valid slot SHALL mark that slot resolved.
REQ-022 Each cycle, if slot head is valid and resolved, the block SHALL free it and increment head; at most one slot is freed per cycle.
REQ-023 A resolve targeting an invalid slot SHALL be ignored.
REQ-024 The block SHALL accept a mispredict resolve only in state IDLE; in other states the mispredict is ignored.
REQ-025 An accepted mispredict on slot k SHALL invalidate slot k and all younger slots, set tail=k, latch slot k's table, and move the state to RESTORE.
REQ-026 FSM transitions SHALL be IDLE->RESTORE->FLUSH->IDLE, with each non-IDLE state lasting exactly one cycle.
REQ-027 In RESTORE, restore_en SHALL be 1 and restore_table SHALL be the latched table.
REQ-028 busy SHALL be 1 in RESTORE and FLUSH and in the cycle a mispredict is accepted.
REQ-029 A mispredict sampled at edge t SHALL produce restore_en high in cycle t+1, and allocation SHALL be permitted again in cycle t+3.
REQ-030 full SHALL equal (count==NUM_CKPT); count SHALL be updated consistently when alloc, head-free and mispredict truncation happen in the same cycle.
REQ-031 A correct resolve and an allocation in the same cycle SHALL both take effect.
REQ-032 A correct resolve of slot head SHALL free that slot in the next cycle, not combinationally.
REQ-033 restore_table SHALL be '0 and restore_en SHALL be 0 outside RESTORE.

Reset
REQ-034 reset_n low SHALL asynchronously set all slots invalid, head=tail=0, count=0, state=IDLE, restore_en=0 and busy=0.
REQ-035 Assertion of reset_n during RESTORE or FLUSH SHALL abort recovery, with no restore_en after release.

Configuration
REQ-036 With CKPT_CDB_SNOOP_EN defined, each cycle the block SHALL set ready=1 in every valid stored entry whose phys_reg matches a valid cdb_broadcasts tag; this includes an entry being allocated in the same cycle and the latched restore table.
REQ-037 Without CKPT_CDB_SNOOP_EN, stored ready bits SHALL stay as captured, and cdb_broadcasts SHALL be unused.

Structure
REQ-038 CKPT_IDX (a $clog2(NUM_CKPT)-bit typedef) and the CKPT_STATE enum SHALL be placed in the shared sys_defs package next to MAP_ENTRY.
REQ-039 The block SHALL use one sub-module, ckpt_slot, holding one stored table and performing the CDB snoop.

Verification
REQ-040 Allocate 4 checkpoints with no resolves -> alloc_id 0,1,2,3; full=1; a 5th alloc_req gets alloc_gnt=0.
REQ-041 Correct-resolve ids 1 then 0 -> count stays 4 until id 0 is resolved, then drops 4->3->2 on consecutive cycles.
REQ-042 With ids 0..3 live, mispredict id 1 -> restore_en high for one cycle with slot 1's table; count=1; tail=1; the next alloc returns id 1 at cycle t+3.
REQ-043 A mispredict while busy=1 is ignored; alloc_req with a mispredict in the same cycle gives alloc_gnt=0.
REQ-044 CKPT_CDB_SNOOP_EN: store phys_reg 40 with ready=0, broadcast tag 40, then mispredict -> restore_table shows ready=1.
REQ-045 Assert reset_n low in the RESTORE cycle -> restore_en falls immediately, count=0 and full=0.

Source files
------------

// File: rtl/map_checkpoint_ctrl_pkg.sv
// Shared rename definitions: map entries, CDB tags, checkpoint index/state.
// CKPT_CDB_SNOOP_EN users call cdb_snoop to wake stored map entries.
package sys_defs;

   localparam int ARCH_REG_SZ = 8;
   localparam int CDB_N       = 2;
   localparam int PHYS_REG_SZ = 64;
   localparam int PR_W        = $clog2(PHYS_REG_SZ);
   localparam int CKPT_NUM    = 4;

   typedef logic [PR_W-1:0] PHYS_REG_TAG;

   typedef struct packed {
      PHYS_REG_TAG phys_reg;
      logic        ready;
   } MAP_ENTRY;

   typedef struct packed {
      logic        valid;
      PHYS_REG_TAG tag;
   } CDB_ENTRY;

   typedef MAP_ENTRY [ARCH_REG_SZ-1:0] MAP_TABLE;
   typedef CDB_ENTRY [CDB_N-1:0]       CDB_BUS;

   typedef logic [$clog2(CKPT_NUM)-1:0] CKPT_IDX;

   typedef enum logic [1:0] {
      CKPT_IDLE,
      CKPT_RESTORE,
      CKPT_FLUSH
   } CKPT_STATE;

   function automatic MAP_TABLE cdb_snoop(
      input MAP_TABLE t,
      input CDB_BUS   c
   );
      MAP_TABLE r;
      r = t;
      for (int a = 0; a < ARCH_REG_SZ; a++) begin
         for (int b = 0; b < CDB_N; b++) begin
            if (c[b].valid && c[b].tag == t[a].phys_reg) begin
               r[a].ready = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/map_checkpoint_ctrl_if.sv
// Dispatch/resolve/recovery signal bundle for the checkpoint controller.
interface map_checkpoint_ctrl_if
   import sys_defs::*;
#(
   parameter int NUM_CKPT = CKPT_NUM
);
   localparam int IDX_W = $clog2(NUM_CKPT);
   localparam int CNT_W = $clog2(NUM_CKPT + 1);

   logic             alloc_req;
   MAP_TABLE         alloc_snapshot;
   logic             alloc_gnt;
   logic [IDX_W-1:0] alloc_id;
   logic             resolve_valid;
   logic [IDX_W-1:0] resolve_id;
   logic             resolve_mispredict;
   CDB_BUS           cdb_broadcasts;
   MAP_TABLE         restore_table;
   logic             restore_en;
   logic             busy;
   logic             full;
   logic [CNT_W-1:0] count;

   modport master (
      output alloc_req, alloc_snapshot,
      output resolve_valid, resolve_id,
      output resolve_mispredict, cdb_broadcasts,
      input  alloc_gnt, alloc_id, restore_table,
      input  restore_en, busy, full, count
   );

   modport slave (
      input  alloc_req, alloc_snapshot,
      input  resolve_valid, resolve_id,
      input  resolve_mispredict, cdb_broadcasts,
      output alloc_gnt, alloc_id, restore_table,
      output restore_en, busy, full, count
   );

endinterface

// File: rtl/map_checkpoint_ctrl_slot.sv
// One stored map table image; wakes entries from the CDB when
// CKPT_CDB_SNOOP_EN is defined.
module ckpt_slot
   import sys_defs::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  logic     wr_en,
   input  logic     live,
   input  MAP_TABLE wr_table,
   input  CDB_BUS   cdb,
   output MAP_TABLE tab_o
);

   MAP_TABLE tab_q, tab_d;

   always_comb begin
      tab_d = tab_q;
`ifdef CKPT_CDB_SNOOP_EN
      if (wr_en) begin
         tab_d = cdb_snoop(wr_table, cdb);
      end else if (live) begin
         tab_d = cdb_snoop(tab_q, cdb);
      end
`else
      if (wr_en) begin
         tab_d = wr_table;
      end
`endif
   end

`ifndef CKPT_CDB_SNOOP_EN
   logic unused_snoop;
   assign unused_snoop = live ^ (^cdb);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tab_q <= '0;
      end else begin
         tab_q <= tab_d;
      end
   end

   assign tab_o = tab_q;

endmodule

// File: rtl/map_checkpoint_ctrl.sv
// Branch checkpoint ring for the rename map with mispredict recovery.
// Optional CDB wake-up of stored tables: CKPT_CDB_SNOOP_EN.
module map_checkpoint_ctrl
   import sys_defs::*;
#(
   parameter int NUM_CKPT = CKPT_NUM
) (
   input logic                  clock,
   input logic                  reset_n,
   map_checkpoint_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_CKPT);
   localparam int CNT_W = $clog2(NUM_CKPT + 1);

   typedef logic [IDX_W-1:0] idx_t;

   CKPT_STATE           state_q, state_d;
   logic [NUM_CKPT-1:0] valid_q, valid_d;
   logic [NUM_CKPT-1:0] resolved_q, resolved_d;
   idx_t                head_q, head_d;
   idx_t                tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   MAP_TABLE            restore_q, restore_d;
   MAP_TABLE            slot_tab [NUM_CKPT];

   idx_t rid;
   logic full;
   logic rsv_acc;
   logic misp_acc;
   logic gnt;
   logic free;

   assign rid      = bus.resolve_id;
   assign full     = (count_q == CNT_W'(NUM_CKPT));
   assign rsv_acc  = bus.resolve_valid && valid_q[rid];
   assign misp_acc = rsv_acc && bus.resolve_mispredict
                  && (state_q == CKPT_IDLE);
   assign gnt      = bus.alloc_req && !full
                  && (state_q == CKPT_IDLE) && !misp_acc;
   // a mispredict on the head itself empties the ring instead
   assign free     = valid_q[head_q] && resolved_q[head_q]
                  && !(misp_acc && rid == head_q);

   for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
      ckpt_slot u_slot (
         .clock    (clock),
         .reset_n  (reset_n),
         .wr_en    (gnt && tail_q == idx_t'(g)),
         .live     (valid_q[g]),
         .wr_table (bus.alloc_snapshot),
         .cdb      (bus.cdb_broadcasts),
         .tab_o    (slot_tab[g])
      );
   end

   always_comb begin
      valid_d    = valid_q;
      resolved_d = resolved_q;
      head_d     = head_q;
      tail_d     = tail_q;
      state_d    = state_q;
      count_d    = '0;
`ifdef CKPT_CDB_SNOOP_EN
      restore_d  = cdb_snoop(restore_q, bus.cdb_broadcasts);
`else
      restore_d  = restore_q;
`endif
      if (rsv_acc && !bus.resolve_mispredict) begin
         resolved_d[rid] = 1'b1;
      end
      if (free) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      // age is distance from head, so wrap needs no special case
      if (misp_acc) begin
         for (int i = 0; i < NUM_CKPT; i++) begin
            if (idx_t'(idx_t'(i) - head_q) >= idx_t'(rid - head_q)) begin
               valid_d[i] = 1'b0;
            end
         end
         tail_d = rid;
`ifdef CKPT_CDB_SNOOP_EN
         restore_d = cdb_snoop(slot_tab[rid], bus.cdb_broadcasts);
`else
         restore_d = slot_tab[rid];
`endif
      end
      if (gnt) begin
         valid_d[tail_q]    = 1'b1;
         resolved_d[tail_q] = 1'b0;
         tail_d             = tail_q + 1'b1;
      end
      for (int i = 0; i < NUM_CKPT; i++) begin
         count_d = count_d + CNT_W'(valid_d[i]);
      end
      unique case (state_q)
         CKPT_IDLE:    if (misp_acc) state_d = CKPT_RESTORE;
         CKPT_RESTORE: state_d = CKPT_FLUSH;
         CKPT_FLUSH:   state_d = CKPT_IDLE;
         default:      state_d = CKPT_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= CKPT_IDLE;
         valid_q    <= '0;
         resolved_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         restore_q  <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         resolved_q <= resolved_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         restore_q  <= restore_d;
      end
   end

   assign bus.alloc_gnt     = gnt;
   assign bus.alloc_id      = tail_q;
   assign bus.restore_en    = (state_q == CKPT_RESTORE);
   assign bus.restore_table = (state_q == CKPT_RESTORE) ? restore_q : '0;
   assign bus.busy          = (state_q != CKPT_IDLE) || misp_acc;
   assign bus.full          = full;
   assign bus.count         = count_q;

endmodule

// File: tb/tb_map_checkpoint_ctrl.sv
// Scoreboard bench for map_checkpoint_ctrl against a queue-based model.
module tb_map_checkpoint_ctrl;
   import sys_defs::*;

   localparam int NC = 4;
   localparam int IW = $clog2(NC);
   localparam int CW = $clog2(NC + 1);

   typedef struct packed {
      logic          gnt;
      logic          busy;
      logic          full;
      logic [CW-1:0] count;
      logic          ren;
   } st_t;

   typedef struct {
      int       id;
      MAP_TABLE tab;
      bit       resolved;
   } ck_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   st_t      exp_st[$];
   int       exp_id[$];
   MAP_TABLE exp_tab[$];

   ck_t      live[$];
   int       tail_m = 0;
   int       recov  = 0;
   MAP_TABLE rtab   = '0;

   always #5 clock = ~clock;

   map_checkpoint_ctrl_if #(.NUM_CKPT(NC)) bus ();

   map_checkpoint_ctrl #(.NUM_CKPT(NC)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic MAP_TABLE rnd_tab();
      MAP_TABLE t;
      for (int a = 0; a < ARCH_REG_SZ; a++) begin
         t[a].phys_reg = PHYS_REG_TAG'($urandom_range(32, 47));
         t[a].ready    = 1'($urandom_range(0, 1));
      end
      return t;
   endfunction

   function automatic CDB_BUS rnd_cdb();
      CDB_BUS c;
      for (int b = 0; b < CDB_N; b++) begin
         c[b].valid = 1'($urandom_range(0, 1));
         c[b].tag   = PHYS_REG_TAG'($urandom_range(32, 47));
      end
      return c;
   endfunction

   function automatic MAP_TABLE snoop_m(input MAP_TABLE t,
                                        input CDB_BUS c);
      MAP_TABLE r;
      r = t;
      for (int a = 0; a < ARCH_REG_SZ; a++)
         for (int b = 0; b < CDB_N; b++)
            if (c[b].valid && c[b].tag == t[a].phys_reg)
               r[a].ready = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      live.delete();
      tail_m = 0;
      recov  = 0;
      rtab   = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      bus.alloc_req          = 1'b0;
      bus.resolve_valid      = 1'b0;
      bus.resolve_mispredict = 1'b0;
      bus.cdb_broadcasts     = '0;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // one cycle: drive inputs, predict outputs, advance the model
   task automatic step(input bit areq, input bit rv, input int rid,
                       input bit mp, input MAP_TABLE snap,
                       input CDB_BUS cdb, input bit rst_mid);
      st_t e;
      int  j;
      bit  misp, gnt, hfree;
      @(negedge clock);
      if (!reset_n) reset_n = 1'b1;
      bus.alloc_req          = areq;
      bus.alloc_snapshot     = snap;
      bus.resolve_valid      = rv;
      bus.resolve_id         = IW'(rid);
      bus.resolve_mispredict = mp;
      bus.cdb_broadcasts     = cdb;
      j = -1;
      for (int i = 0; i < live.size(); i++)
         if (live[i].id == rid) j = i;
      misp = rv && j >= 0 && mp && recov == 0;
      gnt  = areq && live.size() < NC && recov == 0 && !misp;
      if (rst_mid) begin
         e = '0;
         exp_st.push_back(e);
         #2 reset_n = 1'b0;
         model_reset();
         return;
      end
      e.gnt   = gnt;
      e.busy  = recov != 0 || misp;
      e.full  = live.size() == NC;
      e.count = CW'(live.size());
      e.ren   = recov == 2;
      exp_st.push_back(e);
      if (e.ren) exp_tab.push_back(rtab);
      if (gnt) exp_id.push_back(tail_m);
      hfree = live.size() > 0 && live[0].resolved && !(misp && j == 0);
`ifdef CKPT_CDB_SNOOP_EN
      for (int i = 0; i < live.size(); i++)
         live[i].tab = snoop_m(live[i].tab, cdb);
      rtab = snoop_m(rtab, cdb);
      snap = snoop_m(snap, cdb);
`endif
      if (rv && j >= 0 && !mp) live[j].resolved = 1'b1;
      if (misp) begin
         rtab = live[j].tab;
         while (live.size() > j) void'(live.pop_back());
         tail_m = rid;
         recov  = 2;
      end else if (recov > 0) begin
         recov--;
      end
      if (hfree) void'(live.pop_front());
      if (gnt) begin
         live.push_back('{id: tail_m, tab: snap, resolved: 1'b0});
         tail_m = (tail_m + 1) % NC;
      end
   endtask

   always @(negedge clock) begin
      st_t e;
      #4;
      if (exp_st.size() != 0) begin
         e = exp_st.pop_front();
         chk("alloc_gnt", 64'(bus.alloc_gnt), 64'(e.gnt));
         chk("busy", 64'(bus.busy), 64'(e.busy));
         chk("full", 64'(bus.full), 64'(e.full));
         chk("count", 64'(bus.count), 64'(e.count));
         chk("restore_en", 64'(bus.restore_en), 64'(e.ren));
         if (bus.alloc_gnt) begin
            if (exp_id.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL alloc_id actual=%0d required=no_grant",
                        bus.alloc_id);
            end else begin
               chk("alloc_id", 64'(bus.alloc_id),
                   64'(exp_id.pop_front()));
            end
         end
         if (bus.restore_en) begin
            if (exp_tab.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL restore actual=%0h required=no_restore",
                        bus.restore_table);
            end else begin
               chk("restore_table", 64'(bus.restore_table),
                   64'(exp_tab.pop_front()));
            end
         end else begin
            chk("restore_table_idle", 64'(bus.restore_table), 64'(0));
         end
      end
   end

   initial begin
      CDB_BUS   nc;
      CDB_BUS   c;
      MAP_TABLE t;
      nc = '0;
      bus.alloc_req          = 1'b0;
      bus.alloc_snapshot     = '0;
      bus.resolve_valid      = 1'b0;
      bus.resolve_id         = '0;
      bus.resolve_mispredict = 1'b0;
      bus.cdb_broadcasts     = '0;

      // fill to full, then in-order frees
      do_reset();
      step(0, 0, 0, 0, rnd_tab(), nc, 0);
      repeat (5) step(1, 0, 0, 0, rnd_tab(), nc, 0);
      step(0, 1, 1, 0, rnd_tab(), nc, 0);
      step(0, 1, 0, 0, rnd_tab(), nc, 0);
      repeat (3) step(0, 0, 0, 0, rnd_tab(), nc, 0);

      // mispredict id 1 with alloc_req, then a mispredict while busy
      do_reset();
      repeat (4) step(1, 0, 0, 0, rnd_tab(), nc, 0);
      step(1, 1, 1, 1, rnd_tab(), nc, 0);
      step(1, 1, 0, 1, rnd_tab(), nc, 0);
      step(1, 0, 0, 0, rnd_tab(), nc, 0);
      step(1, 0, 0, 0, rnd_tab(), nc, 0);
      step(0, 0, 0, 0, rnd_tab(), nc, 0);

`ifdef CKPT_CDB_SNOOP_EN
      do_reset();
      t = rnd_tab();
      t[0].phys_reg = PHYS_REG_TAG'(40);
      t[0].ready    = 1'b0;
      step(1, 0, 0, 0, t, nc, 0);
      c = nc;
      c[0].valid = 1'b1;
      c[0].tag   = PHYS_REG_TAG'(40);
      step(0, 0, 0, 0, rnd_tab(), c, 0);
      step(0, 1, 0, 1, rnd_tab(), nc, 0);
      repeat (3) step(0, 0, 0, 0, rnd_tab(), nc, 0);
`else
      t = rnd_tab();
      c = nc;
`endif

      // reset in the RESTORE cycle
      do_reset();
      repeat (2) step(1, 0, 0, 0, rnd_tab(), nc, 0);
      step(0, 1, 0, 1, rnd_tab(), nc, 0);
      step(0, 0, 0, 0, rnd_tab(), nc, 1);
      repeat (3) step(0, 0, 0, 0, rnd_tab(), nc, 0);

      do_reset();
      repeat (600) begin
         step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, NC - 1)),
              $urandom_range(0, 9) < 2, rnd_tab(), rnd_cdb(), 0);
      end

      @(negedge clock);
      #6;
      chk("alloc_id_drained", 64'(exp_id.size()), 64'(0));
      chk("restore_drained", 64'(exp_tab.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
